and_ff_sched: RTL and testbench

//  Round-robin scheduler that shares one enabled AND flip-flop (clk/rst_n/enable/a/b -> z) among NREQ requesters.

---
 rtl/and_ff_sched_pkg.sv | 43 ++++
 rtl/and_ff_sched_rr_arbiter.sv | 27 ++
 rtl/and_ff_sched.sv | 127 ++++++++++++
 tb/tb_and_ff_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/and_ff_sched_pkg.sv
// Shared types and helpers for the AND-flop scheduler: FSM states, stats width, round-robin pick.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package and_ff_sched_pkg;

  typedef enum logic {
    RUN = 1'b0,
    CLR = 1'b1
  } state_e;

  localparam int STAT_W    = 16;

  // rr_pick works on a fixed maximum width so one function serves any NREQ up to MAX_REQ.
  localparam int MAX_REQ   = 32;
  localparam int MAX_REQ_W = 5;

  typedef struct packed {
    logic                 found;
    logic [MAX_REQ_W-1:0] idx;
  } pick_t;

  // First set bit of valid at or after ptr, wrapping at nreq. The loop runs from the
  // farthest offset down to the nearest, so the nearest match is the one that remains.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                    input logic [MAX_REQ_W-1:0] ptr,
                                    input int                   nreq);
    pick_t res;
    int    pos;
    res = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        pos = int'(ptr) + k;
        if (pos >= nreq) pos = pos - nreq;
        if (valid[MAX_REQ_W'(pos)]) begin
          res.found = 1'b1;
          res.idx   = MAX_REQ_W'(pos);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/and_ff_sched_rr_arbiter.sv
// Combinational round-robin pick among NREQ valids, starting at rr_ptr (pointer register lives in the parent).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the grant is a pure function of the current valids and pointer.
module rr_arbiter
  import and_ff_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant_onehot,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_found
);

  pick_t pick;

  // Widen to the helper's fixed width, pick, then narrow the result back to this instance.
  always_comb begin
    pick         = rr_pick(MAX_REQ'(req_valid), MAX_REQ_W'(rr_ptr), NREQ);
    grant_found  = pick.found;
    grant_id     = IDW'(pick.idx);
    grant_onehot = pick.found ? (NREQ'(1) << grant_id) : '0;
  end

endmodule

// File: rtl/and_ff_sched.sv
// Round-robin scheduler sharing one enabled AND flop among NREQ requesters, with sequenced one-cycle flop clear.
// Latency: grant in cycle N, tagged result (rsp_valid/rsp_id/rsp_z) in cycle N+1; one result per cycle.
// Backpressure: req_ready is the one-hot grant; no backpressure on responses. Optional stats: AND_FF_SCHED_STATS_EN.
module and_ff_sched
  import and_ff_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_a,
  input  logic [NREQ-1:0] req_b,
  output logic [NREQ-1:0] req_ready,
  input  logic            clr_req,
  output logic            clr_done,
  output logic            ff_rst_n,
  output logic            ff_enable,
  output logic            ff_a,
  output logic            ff_b,
  input  logic            ff_z,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic            rsp_z
`ifdef AND_FF_SCHED_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0] stat_grants
`endif
);

  state_e          state_q;
  state_e          state_d;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  rr_ptr_nxt;
  logic [NREQ-1:0] grant_onehot;
  logic [IDW-1:0]  grant_id;
  logic            grant_found;
  logic            fire;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_valid    (req_valid),
    .rr_ptr       (rr_ptr),
    .grant_onehot (grant_onehot),
    .grant_id     (grant_id),
    .grant_found  (grant_found)
  );

  // Pointer moves to the slot after the winner, wrapping at NREQ (NREQ need not be a power of two).
  assign rr_ptr_nxt = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  // Next state and flop drive. Clear beats requests; everything is held quiet while in reset.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    ff_enable = 1'b0;
    ff_a      = 1'b0;
    ff_b      = 1'b0;
    fire      = 1'b0;
    if (rst_n) begin
      case (state_q)
        RUN: begin
          if (clr_req) begin
            state_d = CLR;
          end else if (grant_found) begin
            fire      = 1'b1;
            req_ready = grant_onehot;
            ff_enable = 1'b1;
            ff_a      = req_a[grant_id];
            ff_b      = req_b[grant_id];
          end
        end
        CLR:     state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // State, pointer and registered outputs. ff_rst_n is low exactly while the FSM sits in CLR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      clr_done  <= 1'b0;
      ff_rst_n  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= fire;
      clr_done  <= (state_q == CLR);
      ff_rst_n  <= (state_d != CLR);
      if (fire) begin
        rr_ptr <= rr_ptr_nxt;
        rsp_id <= grant_id;
      end
    end
  end

  // The flop output is only meaningful in the cycle after a grant.
  assign rsp_z = rsp_valid & ff_z;

`ifdef AND_FF_SCHED_STATS_EN
  logic [STAT_W-1:0] grant_cnt [NREQ];

  // Per-requester saturating grant counters, wiped whenever the flop is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
    end else if (state_q == CLR) begin
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
    end else if (fire) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_id == IDW'(i) && grant_cnt[i] != '1) grant_cnt[i] <= grant_cnt[i] + STAT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_grants[g*STAT_W +: STAT_W] = grant_cnt[g];
  end
`endif

endmodule

// File: tb/tb_and_ff_sched.sv
// Directed, table-driven bench for and_ff_sched with a behavioural AND flop in the loop.
// Inputs change just after the falling edge; comb outputs are sampled before the rising edge, registered ones #1 after it.
// Multi-cycle corners (reset, held clear, mid-operation reset, stats) are hand-written sequences.
module tb_and_ff_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_a;
  logic [3:0]  req_b;
  logic [3:0]  req_ready;
  logic        clr_req;
  logic        clr_done;
  logic        ff_rst_n;
  logic        ff_enable;
  logic        ff_a;
  logic        ff_b;
  logic        ff_z;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic        rsp_z;
`ifdef AND_FF_SCHED_STATS_EN
  logic [63:0] stat_grants;
`endif

  int checks;
  int failures;

  and_ff_sched #(.NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .clr_req   (clr_req),
    .clr_done  (clr_done),
    .ff_rst_n  (ff_rst_n),
    .ff_enable (ff_enable),
    .ff_a      (ff_a),
    .ff_b      (ff_b),
    .ff_z      (ff_z),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z)
`ifdef AND_FF_SCHED_STATS_EN
    ,
    .stat_grants (stat_grants)
`endif
  );

  // The shared enabled AND flop with its own async active-low reset.
  always_ff @(posedge clk or negedge ff_rst_n) begin
    if (!ff_rst_n) ff_z <= 1'b0;
    else if (ff_enable) ff_z <= ff_a & ff_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs for one cycle, the comb outputs expected during it, and the registered
  // outputs plus flop value expected just after its closing edge.
  typedef struct {
    logic [3:0] v, a, b; logic clr;
    logic [3:0] rdy; logic en, fa, fb;
    logic rv; logic [1:0] rid; logic rz, z, frst, cd;
  } vec_t;

  vec_t tbl [20];

  initial begin
    logic [3:0] exp_rdy;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = 4'b1111;
    req_b     = 4'b1111;
    clr_req   = 1'b0;

    // Columns: v, a, b, clr | rdy, en, fa, fb | rv, rid, rz, z, frst, cd
    // Fairness from pointer 0: grants 0,1,2,3,0,1,2,3; z follows b of the winner.
    tbl[0]  = '{4'b1111, 4'b1111, 4'b1010, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{4'b1111, 4'b1111, 4'b1010, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{4'b1111, 4'b1111, 4'b1010, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{4'b1111, 4'b1111, 4'b1010, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{4'b1111, 4'b1111, 4'b1010, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{4'b1111, 4'b1111, 4'b1010, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{4'b1111, 4'b1111, 4'b1010, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{4'b1111, 4'b1111, 4'b1010, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0};
    // Single requester 2 with a=b=1; pointer moves to 3.
    tbl[8]  = '{4'b0100, 4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0};
    // Truth table through requester 1, back to back (search wraps 3 -> 0 -> 1).
    tbl[9]  = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{4'b0010, 4'b0000, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{4'b0010, 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    // Idle: no enable, flop holds 1, response masked to 0.
    tbl[13] = '{4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    // Pointer 2: only req 0 valid -> wraps to 0; then pointer 1 with {3,0} valid -> 3.
    tbl[14] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{4'b1001, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    // Clear: set z=1, then clr_req with {1,0} valid. Clear wins, flop drops at CLR entry,
    // clr_done follows, grants resume from pointer 1.
    tbl[16] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{4'b0011, 4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{4'b0011, 4'b0011, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[19] = '{4'b0011, 4'b0011, 4'b0011, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset with every requester valid: nothing granted, flop held in reset.
    #2;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_enable", 32'(ff_enable), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_ff_rst_n", 32'(ff_rst_n), 32'h0);
    @(posedge clk); #1;
    chk("rst_ff_rst_n_edge", 32'(ff_rst_n), 32'h0);
    chk("rst_clr_done", 32'(clr_done), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    #1;
    chk("rel_ff_rst_n_pre", 32'(ff_rst_n), 32'h0);
    @(posedge clk); #1;
    chk("rel_ff_rst_n_post", 32'(ff_rst_n), 32'h1);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_valid = tbl[i].v;
      req_a     = tbl[i].a;
      req_b     = tbl[i].b;
      clr_req   = tbl[i].clr;
      #1;
      chk($sformatf("row%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d_enable", i), 32'(ff_enable), 32'(tbl[i].en));
      chk($sformatf("row%0d_ff_a", i), 32'(ff_a), 32'(tbl[i].fa));
      chk($sformatf("row%0d_ff_b", i), 32'(ff_b), 32'(tbl[i].fb));
      @(posedge clk); #1;
      chk($sformatf("row%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("row%0d_rsp_id", i), 32'(rsp_id), 32'(tbl[i].rid));
      chk($sformatf("row%0d_rsp_z", i), 32'(rsp_z), 32'(tbl[i].rz));
      chk($sformatf("row%0d_ff_z", i), 32'(ff_z), 32'(tbl[i].z));
      chk($sformatf("row%0d_ff_rst_n", i), 32'(ff_rst_n), 32'(tbl[i].frst));
      chk($sformatf("row%0d_clr_done", i), 32'(clr_done), 32'(tbl[i].cd));
    end

`ifdef AND_FF_SCHED_STATS_EN
    // Counters were wiped by the clear above; since then req 1 won once. Add five wins for req 3.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 4'b1000;
      clr_req   = 1'b0;
      @(posedge clk); #1;
    end
    chk("stat_req3", stat_grants[63:48], 32'd5);
    chk("stat_req1", stat_grants[31:16], 32'd1);
`endif

    // clr_req held high: CLR, one RUN cycle without grant, CLR again.
    @(negedge clk);
    req_valid = 4'b1111;
    clr_req   = 1'b1;
    #1;
    chk("hold_a_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    chk("hold_a_ff_rst_n", 32'(ff_rst_n), 32'h0);
    @(negedge clk); #1;
    chk("hold_b_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    chk("hold_b_ff_rst_n", 32'(ff_rst_n), 32'h1);
    chk("hold_b_clr_done", 32'(clr_done), 32'h1);
    @(negedge clk); #1;
    chk("hold_c_ready", 32'(req_ready), 32'h0);
    chk("hold_c_enable", 32'(ff_enable), 32'h0);
    @(posedge clk); #1;
    chk("hold_c_ff_rst_n", 32'(ff_rst_n), 32'h0);
    chk("hold_c_clr_done", 32'(clr_done), 32'h0);
    @(negedge clk);
    clr_req = 1'b0;
    @(posedge clk); #1;
    chk("hold_d_ff_rst_n", 32'(ff_rst_n), 32'h1);
    chk("hold_d_clr_done", 32'(clr_done), 32'h1);
`ifdef AND_FF_SCHED_STATS_EN
    chk("stat_cleared", stat_grants[31:0], 32'h0);
    chk("stat_cleared_hi", stat_grants[63:32], 32'h0);
    exp_rdy = 4'b0001;   // pointer wrapped to 0 after the req 3 grants
`else
    exp_rdy = 4'b0100;   // pointer still 2 from the last table row
`endif
    @(negedge clk); #1;
    chk("hold_resume_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk); #1;

    // Mid-operation reset: pending response vanishes at once, pointer returns to 0.
    @(negedge clk);
    req_valid = 4'b0100;
    req_a     = 4'b0000;
    req_b     = 4'b0000;
    @(posedge clk); #1;
    chk("mid_rsp_valid_pre", 32'(rsp_valid), 32'h1);
    chk("mid_rsp_id_pre", 32'(rsp_id), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_ready", 32'(req_ready), 32'h0);
    chk("mid_ff_rst_n", 32'(ff_rst_n), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("mid_ptr_zero", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    chk("mid_rsp_after", 32'(rsp_valid), 32'h1);
    chk("mid_rsp_id_after", 32'(rsp_id), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
